vram_port: RTL and testbench



---
 rtl/zed64_vram_pkg.sv | 24 ++
 rtl/vram_wfifo.sv | 57 +++++
 rtl/vram_port.sv | 146 ++++++++++++++
 tb/tb_vram_port.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zed64_vram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | zed64_vram_pkg : shared types for the glyph VRAM port              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package zed64_vram_pkg;

  localparam int VRAM_ADR_W     = 13;
  // Queued write requests carry a fixed-width address; ADR_W up to 16 fits.
  localparam int VRAM_ADR_MAX_W = 16;

  typedef struct packed {
    logic [VRAM_ADR_MAX_W-1:0] adr;
    logic [7:0]                dat;
  } vram_wreq_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RDWAIT = 2'd1,
    S_RDDATA = 2'd2
  } vram_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_wfifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_wfifo : synchronous FIFO of pending VRAM write requests       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vram_wfifo
  import zed64_vram_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  vram_wreq_t  push_data,
  input  logic        pop,
  output vram_wreq_t  pop_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  vram_wreq_t    store_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = store_q[rd_ptr_q];
  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;

endmodule
`default_nettype wire

// File: rtl/vram_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vram_port : glyph VRAM with video fetch, buffered host writes and  |
// |             optional ordered host reads (define VRAM_HOSTREAD_EN)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vram_port
  import zed64_vram_pkg::*;
#(
  parameter  int FIFO_DEPTH    = 8,
  parameter  bit WRITE_ANYTIME = 1'b0,
  parameter  int ADR_W         = VRAM_ADR_W,
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             pixel_clock,
  input  logic             reset_n,
  input  logic [ADR_W-1:0] vid_adr,
  output logic [7:0]       vid_dat,
  input  logic             vid_blank,
  input  logic             host_valid,
  input  logic             host_we,
  input  logic [ADR_W-1:0] host_adr,
  input  logic [7:0]       host_wdat,
  output logic             host_ready,
  output logic             host_rvalid,
  output logic [7:0]       host_rdat,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
);

  logic [7:0]       mem [2**ADR_W];
  logic             slot_open, full, empty, push, pop, steal;
  vram_wreq_t       push_req, pop_req;
  logic [ADR_W-1:0] rd_adr;
  logic [7:0]       rd_word;
  logic [7:0]       vid_dat_q, vid_dat_d, host_rdat_q, host_rdat_d;
  logic             host_rvalid_q, host_rvalid_d, overflow_q, overflow_d;

  assign slot_open = vid_blank | WRITE_ANYTIME;
  assign push      = host_valid & host_ready & host_we;
  assign pop       = slot_open & ~empty;
  assign push_req  = {VRAM_ADR_MAX_W'(host_adr), host_wdat};

  vram_wfifo #(
    .DEPTH     (FIFO_DEPTH)
  ) u_wfifo (
    .clk       (pixel_clock),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (pop_req),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  // Nonblocking write with a combinational read gives read-before-write.
  always_ff @(posedge pixel_clock) begin
    if (pop) mem[ADR_W'(pop_req.adr)] <= pop_req.dat;
  end

  assign rd_word = mem[rd_adr];

`ifdef VRAM_HOSTREAD_EN
  vram_state_t      state_q, state_d;
  logic [ADR_W-1:0] rd_adr_q, rd_adr_d;

  assign host_ready = (state_q == S_IDLE) & (host_we ? ~full : 1'b1);

  // The read waits for an empty FIFO so every earlier write is visible.
  always_comb begin
    state_d       = state_q;
    rd_adr_d      = rd_adr_q;
    steal         = 1'b0;
    host_rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host_valid & host_ready & ~host_we) begin
          rd_adr_d = host_adr;
          state_d  = S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (empty & slot_open) begin
          steal         = 1'b1;
          host_rvalid_d = 1'b1;
          state_d       = S_RDDATA;
        end
      end
      S_RDDATA: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rd_adr_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_adr_q <= rd_adr_d;
    end
  end

  always_comb begin
    rd_adr      = steal ? rd_adr_q : vid_adr;
    host_rdat_d = steal ? rd_word : host_rdat_q;
  end
`else
  assign host_ready = host_we ? ~full : 1'b1;

  always_comb begin
    steal         = 1'b0;
    rd_adr        = vid_adr;
    host_rvalid_d = host_valid & host_ready & ~host_we;
    host_rdat_d   = 8'h00;
  end
`endif

  always_comb begin
    vid_dat_d  = steal ? vid_dat_q : rd_word;
    overflow_d = overflow_q | (host_valid & host_we & full);
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      vid_dat_q     <= 8'h00;
      host_rdat_q   <= 8'h00;
      host_rvalid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      vid_dat_q     <= vid_dat_d;
      host_rdat_q   <= host_rdat_d;
      host_rvalid_q <= host_rvalid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign vid_dat     = vid_dat_q;
  assign host_rdat   = host_rdat_q;
  assign host_rvalid = host_rvalid_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vram_port : directed + random bench with a queue/array model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_vram_port;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [12:0] vid_adr;
  logic [7:0]  vid_dat;
  logic        vid_blank;
  logic        host_valid;
  logic        host_we;
  logic [12:0] host_adr;
  logic [7:0]  host_wdat;
  logic        host_ready;
  logic        host_rvalid;
  logic [7:0]  host_rdat;
  logic [3:0]  fifo_level;
  logic        overflow;

  vram_port #(
    .FIFO_DEPTH    (DEPTH),
    .WRITE_ANYTIME (1'b0),
    .ADR_W         (13)
  ) dut (
    .pixel_clock (clk),
    .reset_n     (rst_n),
    .vid_adr     (vid_adr),
    .vid_dat     (vid_dat),
    .vid_blank   (vid_blank),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_adr    (host_adr),
    .host_wdat   (host_wdat),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_rdat   (host_rdat),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: known memory bytes, pending-write queue, pending read.
  logic [7:0] mm [int];
  int         wq [$];
  int         ph;
  int         rd_a;
  logic [7:0] m_vid, m_rdat;
  logic       m_vid_k, m_rdat_k, m_ovf;
  int         pool [6];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    ph       = 0;
    m_vid    = 8'h00;
    m_vid_k  = 1'b1;
    m_rdat   = 8'h00;
    m_rdat_k = 1'b1;
    m_ovf    = 1'b0;
  endtask

  // One clock: check ready, advance the model over the edge, check outputs.
  task automatic cycle();
    logic exp_ready, acc, slot, steal, fire;
    int   e;
    #1;
    slot      = vid_blank;
    exp_ready = (ph == 0) && (host_we ? (wq.size() < DEPTH) : 1'b1);
    check("host_ready", 32'(host_ready), 32'(exp_ready));
    acc   = host_valid && exp_ready;
    steal = 1'b0;
    fire  = 1'b0;
    if (host_valid && host_we && wq.size() == DEPTH) m_ovf = 1'b1;
`ifdef VRAM_HOSTREAD_EN
    if (ph == 2) ph = 0;
    else if (ph == 1 && wq.size() == 0 && slot) begin
      steal    = 1'b1;
      fire     = 1'b1;
      ph       = 2;
      m_rdat_k = mm.exists(rd_a);
      if (m_rdat_k) m_rdat = mm[rd_a];
    end
    if (acc && !host_we) begin
      ph   = 1;
      rd_a = int'(host_adr);
    end
`else
    if (acc && !host_we) begin
      fire     = 1'b1;
      m_rdat   = 8'h00;
      m_rdat_k = 1'b1;
    end
`endif
    if (!steal) begin
      m_vid_k = mm.exists(int'(vid_adr));
      if (m_vid_k) m_vid = mm[int'(vid_adr)];
    end
    if (slot && wq.size() > 0) begin
      e = wq.pop_front();
      mm[e >> 8] = 8'(e);
    end
    if (acc && host_we) wq.push_back((int'(host_adr) << 8) | int'(host_wdat));
    @(posedge clk);
    #1;
    if (m_vid_k)  check("vid_dat", 32'(vid_dat), 32'(m_vid));
    if (m_rdat_k) check("host_rdat", 32'(host_rdat), 32'(m_rdat));
    check("host_rvalid", 32'(host_rvalid), 32'(fire));
    check("fifo_level", 32'(fifo_level), 32'(wq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic host_write(input logic [12:0] a, input logic [7:0] d);
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_adr   = a;
    host_wdat  = d;
    cycle();
    host_valid = 1'b0;
  endtask

  task automatic host_read(input logic [12:0] a);
    host_valid = 1'b1;
    host_we    = 1'b0;
    host_adr   = a;
    cycle();
    host_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] keep [3];
    rst_n      = 1'b0;
    vid_blank  = 1'b0;
    vid_adr    = '0;
    host_valid = 1'b0;
    host_we    = 1'b0;
    host_adr   = '0;
    host_wdat  = '0;
    for (int i = 0; i < 6; i++) pool[i] = int'($urandom_range(0, 8191));
    repeat (3) @(posedge clk);
    #1;
    check("rst_vid_dat", 32'(vid_dat), 32'h0);
    check("rst_host_rdat", 32'(host_rdat), 32'h0);
    check("rst_host_rvalid", 32'(host_rvalid), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_fifo_level", 32'(fifo_level), 32'h0);
    host_we = 1'b1;
    #1;
    check("rst_host_ready", 32'(host_ready), 32'h1);
    host_we = 1'b0;
    model_reset();
    rst_n = 1'b1;

    // Preload a few known bytes during blanking.
    vid_blank = 1'b1;
    host_write(13'h0010, 8'h5A);
    host_write(13'h1234, 8'(($urandom_range(0, 254) + 1) ^ 8'hA5));
    host_write(13'h0100, 8'h11);
    repeat (2) cycle();

    // Video-only fetch, latency 1, holds while address held.
    vid_blank = 1'b0;
    vid_adr   = 13'h0010;
    repeat (4) cycle();
    check("vid_preload", 32'(vid_dat), 32'h5A);

    // Write queued in active video, committed on blank.
    vid_adr = 13'h1234;
    host_write(13'h1234, 8'hA5);
    check("level_one", 32'(fifo_level), 32'h1);
    repeat (2) cycle();
    vid_blank = 1'b1;
    repeat (2) cycle();
    check("vid_after_drain", 32'(vid_dat), 32'hA5);
    check("level_drained", 32'(fifo_level), 32'h0);

    // Fill the FIFO, overflow on the ninth write, then drain.
    vid_blank = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) host_write(13'(pool[i % 6]), 8'($urandom));
    check("level_full", 32'(fifo_level), 32'(DEPTH));
    check("overflow_set", 32'(overflow), 32'h1);
    repeat (3) cycle();
    vid_blank = 1'b1;
    repeat (DEPTH + 1) cycle();
    check("overflow_sticky", 32'(overflow), 32'h1);

    // Ordered read behind a queued write.
    vid_blank = 1'b0;
    vid_adr   = 13'h0010;
    host_write(13'h0100, 8'h3C);
    host_read(13'h0100);
    repeat (4) cycle();
    vid_blank = 1'b1;
    repeat (4) cycle();
`ifdef VRAM_HOSTREAD_EN
    check("host_rdat_ordered", 32'(host_rdat), 32'h3C);
`else
    check("host_rdat_stub", 32'(host_rdat), 32'h00);
`endif

    // Randomised traffic over a small address pool.
    for (int i = 0; i < 400; i++) begin
      vid_blank  = ($urandom_range(0, 2) == 0);
      vid_adr    = 13'(pool[$urandom_range(0, 5)]);
      host_valid = ($urandom_range(0, 9) < 6);
      host_we    = ($urandom_range(0, 9) < 6);
      host_adr   = 13'(pool[$urandom_range(0, 5)]);
      host_wdat  = 8'($urandom);
      cycle();
    end
    host_valid = 1'b0;

    // Reset with writes queued and a read pending.
    vid_blank = 1'b1;
    repeat (DEPTH + 3) cycle();
    for (int i = 0; i < 3; i++) begin
      keep[i] = 8'($urandom);
      host_write(13'(pool[i]), keep[i]);
    end
    repeat (2) cycle();
    vid_blank = 1'b0;
    for (int i = 0; i < 3; i++) host_write(13'(pool[i]), ~keep[i]);
    host_read(13'(pool[3]));
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_level", 32'(fifo_level), 32'h0);
    check("midrst_rvalid", 32'(host_rvalid), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    host_we = 1'b1;
    #1;
    check("postrst_ready", 32'(host_ready), 32'h1);
    host_we = 1'b0;
    vid_blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vid_adr = 13'(pool[i]);
      repeat (2) cycle();
      if (pool[i] != pool[(i + 1) % 3] && pool[i] != pool[(i + 2) % 3])
        check("old_contents", 32'(vid_dat), 32'(keep[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
